// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder slice.
//   MEM_WORD_WIDTH : data word width
//   WAIT_CNT_WIDTH : width of the wait-cycle counter (wait_cycles up to 15)
//   state_e        : responder FSM state encoding (Idle=0, Wait=1, Commit=2, Resp=3)
package mem_pkg;

    localparam int unsigned MEM_WORD_WIDTH = 32;
    localparam int unsigned WAIT_CNT_WIDTH = 4;

    typedef logic [WAIT_CNT_WIDTH-1:0] wait_cnt_t;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWait   = 2'd1,
        StCommit = 2'd2,
        StResp   = 2'd3
    } state_e;

endpackage

// File: rtl/mem_array.sv
// Word storage for the memory responder: depth x MEM_WORD_WIDTH.
// Ports:
//   clk           : clock, write happens on the rising edge
//   write_enable  : store write_data at write_address this edge
//   write_address : word index for the write port
//   write_data    : word to store
//   read_address  : word index for the combinational read port
//   read_data     : contents of read_address (no register)
// Contents are not reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned depth = 2048
) (
    input  logic                      clk,
    input  logic                      write_enable,
    input  logic [$clog2(depth)-1:0]  write_address,
    input  logic [MEM_WORD_WIDTH-1:0] write_data,
    input  logic [$clog2(depth)-1:0]  read_address,
    output logic [MEM_WORD_WIDTH-1:0] read_data
);

    logic [MEM_WORD_WIDTH-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (write_enable) begin
            mem[write_address] <= write_data;
        end
    end

    assign read_data = mem[read_address];

endmodule

// File: rtl/mem_responder.sv
// Responder end of the CPU memory request interface with a fixed response latency.
// One request at a time: accepted in Idle, held through Wait, applied to the array in
// Commit, and presented in Resp until the initiator takes it.
// Ports:
//   clk, rst        : clock and asynchronous active-low reset
//   req_valid/ready : request handshake (ready only in Idle and never during reset)
//   req_write       : 1 = write, 0 = read
//   req_address     : word address; low $clog2(depth) bits select the word
//   req_write_data  : write data
//   resp_valid/ready: response handshake
//   resp_data       : read data, 0 for writes
//   resp_err        : only with MEM_RESP_ERR_EN; flags an address >= depth, in which case
//                     writes are dropped and reads return 0 instead of wrapping
// Optional feature macro: MEM_RESP_ERR_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned depth       = 2048,
    parameter int unsigned wait_cycles = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [31:0]               req_address,
    input  logic [MEM_WORD_WIDTH-1:0] req_write_data,
    output logic                      resp_valid,
    input  logic                      resp_ready,
`ifdef MEM_RESP_ERR_EN
    output logic                      resp_err,
`endif
    output logic [MEM_WORD_WIDTH-1:0] resp_data
);

    localparam int unsigned AddrWidth = $clog2(depth);

    state_e                    state_q, state_d;
    wait_cnt_t                 cnt_q, cnt_d;
    logic                      write_q;
    logic [AddrWidth-1:0]      index_q;
    logic [MEM_WORD_WIDTH-1:0] wdata_q;
    logic [MEM_WORD_WIDTH-1:0] resp_data_q, resp_data_d;
    logic [MEM_WORD_WIDTH-1:0] read_data;
    logic                      accept;
    logic                      array_we;
    logic                      in_range;

`ifdef MEM_RESP_ERR_EN
    logic oor_q;
    logic err_q, err_d;
    assign in_range = ~oor_q;
    assign resp_err = err_q;
`else
    // Upper address bits are deliberately ignored so addresses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_address[31:AddrWidth];
    assign in_range = 1'b1;
`endif

    assign req_ready  = rst && (state_q == StIdle);
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == StResp);
    assign resp_data  = resp_data_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        resp_data_d = resp_data_q;
        array_we    = 1'b0;
`ifdef MEM_RESP_ERR_EN
        err_d       = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                // Wait always spans wait_cycles+1 cycles, which puts the response
                // wait_cycles+2 edges after acceptance even when wait_cycles is 0.
                if (accept) begin
                    state_d = StWait;
                    cnt_d   = WAIT_CNT_WIDTH'(wait_cycles);
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StCommit;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StCommit: begin
                array_we    = write_q && in_range;
                resp_data_d = (write_q || !in_range) ? '0 : read_data;
`ifdef MEM_RESP_ERR_EN
                err_d       = !in_range;
`endif
                state_d     = StResp;
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            resp_data_q <= '0;
`ifdef MEM_RESP_ERR_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            resp_data_q <= resp_data_d;
`ifdef MEM_RESP_ERR_EN
            err_q       <= err_d;
`endif
        end
    end

    // Request capture; only changes on an accepted handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_q <= 1'b0;
            index_q <= '0;
            wdata_q <= '0;
`ifdef MEM_RESP_ERR_EN
            oor_q   <= 1'b0;
`endif
        end else if (accept) begin
            write_q <= req_write;
            index_q <= req_address[AddrWidth-1:0];
            wdata_q <= req_write_data;
`ifdef MEM_RESP_ERR_EN
            oor_q   <= (req_address >= 32'(depth));
`endif
        end
    end

    mem_array #(
        .depth(depth)
    ) u_array (
        .clk          (clk),
        .write_enable (array_we),
        .write_address(index_q),
        .write_data   (wdata_q),
        .read_address (index_q),
        .read_data    (read_data)
    );

endmodule
